// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the uart transmit arbiter.
package uart_tx_arbiter_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StRetry,
        StWaitDone,
        StHold
    } arb_state_e;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin winner select: rotate by ptr, priority-encode, unrotate.
module uart_tx_arbiter_rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [N_REQ-1:0] rotated;
    int unsigned      p;
    int unsigned      enc;
    int unsigned      sum;

    always_comb begin
        p       = 32'(ptr);
        rotated = '0;
        enc     = 0;
        any     = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            rotated[i] = valid[(i + p) % N_REQ];
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (rotated[i] && !any) begin
                enc = i;
                any = 1'b1;
            end
        end
        sum = enc + p;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end
        idx    = IDX_W'(sum);
        onehot = '0;
        for (int k = 0; k < N_REQ; k++) begin
            onehot[k] = any && (idx == IDX_W'(k));
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart transmitter among N_REQ byte-stream requesters, one locked packet at a time.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned IDX_W       = 2,
    parameter int unsigned ACK_TIMEOUT = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    input  logic [N_REQ-1:0]   req_last_i,
    output logic [N_REQ-1:0]   req_ready_o,
    output logic [N_REQ-1:0]   grant_o,
    output logic [7:0]         tx_data_o,
    output logic               tx_start_o,
    input  logic               tx_busy_i,
    output logic               active_o,
    output logic               err_timeout_o
);

    localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT + 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             lock_q, lock_d;
    logic             last_q, last_d;
    logic [7:0]       data_q, data_d;
    logic [TMR_W-1:0] timer_q, timer_d;

    logic [N_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             owner_valid;
    logic             owner_last;
    logic [7:0]       owner_byte;

    uart_tx_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .valid  (req_valid_i),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_byte  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (owner_q == IDX_W'(k)) begin
                owner_valid = req_valid_i[k];
                owner_last  = req_last_i[k];
                owner_byte  = req_data_i[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        owner_d       = owner_q;
        grant_d       = grant_q;
        lock_d        = lock_q;
        last_d        = last_q;
        data_d        = data_q;
        timer_d       = '0;
        req_ready_o   = '0;
        tx_start_o    = 1'b0;
        err_timeout_o = 1'b0;
        case (state_q)
            StIdle: begin
                // A frame left over from before reset must drain before we start our own.
                if (!lock_q && pick_any && !tx_busy_i) begin
                    owner_d = pick_idx;
                    grant_d = pick_onehot;
                    lock_d  = 1'b1;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                req_ready_o = grant_q;
                data_d      = owner_byte;
                last_d      = owner_last;
                state_d     = StStart;
            end
            StStart: begin
                tx_start_o = 1'b1;
                if (tx_busy_i) begin
                    state_d = StWaitDone;
                end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
                    err_timeout_o = 1'b1;
                    state_d       = StRetry;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            StRetry: state_d = StStart;
            StWaitDone: begin
                if (!tx_busy_i) begin
                    if (last_q) begin
                        grant_d = '0;
                        lock_d  = 1'b0;
                        ptr_d   = IDX_W'(wrap_inc(32'(owner_q), N_REQ));
                        state_d = StIdle;
                    end else if (owner_valid) begin
                        state_d = StLoad;
                    end else begin
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (owner_valid) begin
                    state_d = StLoad;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            owner_q <= '0;
            grant_q <= '0;
            lock_q  <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            lock_q  <= lock_d;
            last_q  <= last_d;
            data_q  <= data_d;
            timer_q <= timer_d;
        end
    end

    assign grant_o   = grant_q;
    assign tx_data_o = data_q;
    assign active_o  = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: uart and requester models, a per-cycle reference, directed scenarios.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int AT = 8;

    logic           clk         = 1'b0;
    logic           rst_i       = 1'b1;
    logic [N-1:0]   req_valid_i = '0;
    logic [8*N-1:0] req_data_i  = '0;
    logic [N-1:0]   req_last_i  = '0;
    logic           tx_busy_i   = 1'b0;
    logic [N-1:0]   req_ready_o;
    logic [N-1:0]   grant_o;
    logic [7:0]     tx_data_o;
    logic           tx_start_o;
    logic           active_o;
    logic           err_timeout_o;

    uart_tx_arbiter #(
        .N_REQ       (N),
        .IDX_W       (2),
        .ACK_TIMEOUT (AT)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_data_i    (req_data_i),
        .req_last_i    (req_last_i),
        .req_ready_o   (req_ready_o),
        .grant_o       (grant_o),
        .tx_data_o     (tx_data_o),
        .tx_start_o    (tx_start_o),
        .tx_busy_i     (tx_busy_i),
        .active_o      (active_o),
        .err_timeout_o (err_timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        bit         last;
        int         gap;
    } item_t;

    int    checks = 0;
    int    errors = 0;
    item_t src[N][$];
    int    wait_cnt[N];
    int    rdy_cnt[N];
    int    log_q[$];
    int    exp_q[$];
    int    err_times[$];
    bit    no_ack = 1'b0;
    bit    armed = 1'b0;
    int    busy_cnt = 0;
    int    cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int k, input logic [7:0] d, input bit l, input int g);
        item_t it;
        it.data = d;
        it.last = l;
        it.gap  = g;
        src[k].push_back(it);
    endtask

    function automatic int oh2idx(input logic [N-1:0] oh);
        for (int i = 0; i < N; i++) if (oh[i]) return i;
        return 15;
    endfunction

    // Uart (busy 2 cycles after start, held 20 cycles) and requester sources.
    initial begin
        logic         s_start;
        logic [N-1:0] s_rdy;
        logic [N-1:0] s_grant;
        logic [7:0]   s_data;
        for (int k = 0; k < N; k++) begin
            wait_cnt[k] = 0;
            rdy_cnt[k]  = 0;
        end
        forever begin
            @(negedge clk);
            s_start = tx_start_o;
            s_rdy   = req_ready_o;
            s_grant = grant_o;
            s_data  = tx_data_o;
            @(posedge clk);
            #1;
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) tx_busy_i = 1'b0;
            end else if (armed) begin
                armed     = 1'b0;
                tx_busy_i = 1'b1;
                busy_cnt  = 20;
            end else if (s_start && !no_ack) begin
                armed = 1'b1;
                log_q.push_back(oh2idx(s_grant) * 256 + int'(s_data));
            end
            for (int k = 0; k < N; k++) begin
                if (s_rdy[k]) begin
                    rdy_cnt[k]++;
                    if (src[k].size() > 0) wait_cnt[k] = src[k].pop_front().gap;
                end
                if (wait_cnt[k] > 0) begin
                    wait_cnt[k]--;
                    req_valid_i[k] = 1'b0;
                    req_last_i[k]  = 1'b0;
                end else if (src[k].size() > 0) begin
                    req_valid_i[k]         = 1'b1;
                    req_last_i[k]          = src[k][0].last;
                    req_data_i[8*k +: 8]   = src[k][0].data;
                end else begin
                    req_valid_i[k] = 1'b0;
                    req_last_i[k]  = 1'b0;
                end
            end
        end
    end

    // Reference: packet-level rules tracked per cycle.
    int         m_owner = -1;
    int         m_ptr = 0;
    int         m_timer = 0;
    bit         m_load, m_start, m_retry, m_air, m_hold, m_last;
    logic [7:0] m_data = '0;

    function automatic int rr_winner(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++) if (v[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    always @(negedge clk) begin
        logic [N-1:0] eg;
        logic [N-1:0] er;
        logic         ee;
        cyc++;
        if (rst_i) begin
            check("rst_grant", 32'(grant_o), 0);
            check("rst_ready", 32'(req_ready_o), 0);
            check("rst_start", 32'(tx_start_o), 0);
            check("rst_active", 32'(active_o), 0);
            check("rst_data", 32'(tx_data_o), 0);
            check("rst_err", 32'(err_timeout_o), 0);
            m_owner = -1; m_ptr = 0; m_timer = 0; m_data = '0;
            m_load = 0; m_start = 0; m_retry = 0; m_air = 0; m_hold = 0; m_last = 0;
        end else begin
            eg = '0;
            er = '0;
            if (m_owner >= 0) eg[m_owner] = 1'b1;
            if (m_load) er[m_owner] = 1'b1;
            ee = m_start && !tx_busy_i && (m_timer == AT - 1);
            check("cyc_grant", 32'(grant_o), 32'(eg));
            check("cyc_ready", 32'(req_ready_o), 32'(er));
            check("cyc_start", 32'(tx_start_o), 32'(m_start));
            check("cyc_active", 32'(active_o), 32'(m_owner >= 0));
            check("cyc_data", 32'(tx_data_o), 32'(m_data));
            check("cyc_err", 32'(err_timeout_o), 32'(ee));
            check("cyc_ready_valid", 32'(req_ready_o & ~req_valid_i), 0);
            if (err_timeout_o) err_times.push_back(cyc);
            if (m_owner < 0) begin
                if (!tx_busy_i && req_valid_i != 0) begin
                    m_owner = rr_winner(req_valid_i, m_ptr);
                    m_load  = 1;
                end
            end else if (m_load) begin
                m_load  = 0;
                m_data  = req_data_i[8*m_owner +: 8];
                m_last  = req_last_i[m_owner];
                m_start = 1;
                m_timer = 0;
            end else if (m_start) begin
                if (tx_busy_i) begin
                    m_start = 0;
                    m_air   = 1;
                end else if (m_timer == AT - 1) begin
                    m_start = 0;
                    m_retry = 1;
                end else begin
                    m_timer++;
                end
            end else if (m_retry) begin
                m_retry = 0;
                m_start = 1;
                m_timer = 0;
            end else if (m_air) begin
                if (!tx_busy_i) begin
                    m_air = 0;
                    if (m_last) begin
                        m_ptr   = (m_owner + 1) % N;
                        m_owner = -1;
                    end else if (req_valid_i[m_owner]) begin
                        m_load = 1;
                    end else begin
                        m_hold = 1;
                    end
                end
            end else if (m_hold) begin
                if (req_valid_i[m_owner]) begin
                    m_hold = 0;
                    m_load = 1;
                end
            end
        end
    end

    task automatic wait_idle(input string name);
        int  t = 0;
        bit  busy_src;
        busy_src = 1'b1;
        while (t < 3000 && busy_src) begin
            @(negedge clk);
            t++;
            busy_src = active_o || tx_busy_i || armed || (req_valid_i != 0);
            for (int k = 0; k < N; k++) if (src[k].size() > 0) busy_src = 1'b1;
        end
        check(name, 32'(t < 3000), 1);
    endtask

    task automatic wait_busy(input string name);
        int t = 0;
        while (t < 200 && !tx_busy_i) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(t < 200), 1);
    endtask

    task automatic check_log(input string name);
        check({name, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
            check(name, 32'(log_q[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic clear_counts();
        log_q = {};
        for (int k = 0; k < N; k++) rdy_cnt[k] = 0;
    endtask

    initial begin
        int t;
        int early;
        repeat (3) @(negedge clk);
        check("init_active", 32'(active_o), 0);
        check("init_grant", 32'(grant_o), 0);
        @(posedge clk);
        #1 rst_i = 1'b0;

        // Reset while the uart is mid-frame.
        clear_counts();
        push(0, 8'h3C, 1, 0);
        wait_busy("reset_busy_seen");
        repeat (3) @(negedge clk);
        push(0, 8'h77, 1, 0);
        @(posedge clk);
        #3 rst_i = 1'b1;
        #1;
        check("async_rst_grant", 32'(grant_o), 0);
        check("async_rst_ready", 32'(req_ready_o), 0);
        check("async_rst_start", 32'(tx_start_o), 0);
        check("async_rst_active", 32'(active_o), 0);
        check("async_rst_data", 32'(tx_data_o), 0);
        check("async_rst_err", 32'(err_timeout_o), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_i = 1'b0;
        early = 0;
        t = 0;
        while (tx_busy_i && t < 100) begin
            @(negedge clk);
            if (tx_start_o) early++;
            t++;
        end
        check("reset_busy_fell", 32'(t < 100), 1);
        check("reset_no_start_while_busy", 32'(early), 0);
        wait_idle("reset_idle");
        exp_q = '{'h03C, 'h077};
        check_log("reset_log");

        // Single byte from requester 1.
        clear_counts();
        push(1, 8'hA5, 1, 0);
        wait_busy("single_busy_seen");
        check("single_grant", 32'(grant_o), 32'h2);
        check("single_data", 32'(tx_data_o), 32'hA5);
        wait_idle("single_idle");
        check("single_ready1", 32'(rdy_cnt[1]), 1);
        check("single_ready_others", 32'(rdy_cnt[0] + rdy_cnt[2] + rdy_cnt[3]), 0);
        exp_q = '{'h1A5};
        check_log("single_log");

        // Round robin from ptr = 2 with every requester busy.
        clear_counts();
        for (int k = 0; k < N; k++) begin
            push(k, 8'hA0 + 8'(k), 1, 0);
            push(k, 8'hB0 + 8'(k), 1, 0);
        end
        wait_idle("rr_idle");
        exp_q = '{'h2A2, 'h3A3, 'h0A0, 'h1A1, 'h2B2, 'h3B3, 'h0B0, 'h1B1};
        check_log("rr_log");

        // Locked 3-byte packet with a long gap; requester 3 must wait.
        clear_counts();
        push(0, 8'h11, 0, 0);
        push(0, 8'h22, 0, 50);
        push(0, 8'h33, 1, 0);
        t = 0;
        while (grant_o != 4'b0001 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("lock_grant0_seen", 32'(t < 100), 1);
        push(3, 8'h44, 1, 0);
        t = 0;
        while (rdy_cnt[0] < 2 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("lock_second_byte", 32'(t < 200), 1);
        repeat (35) @(negedge clk);
        check("hold_grant", 32'(grant_o), 32'h1);
        check("hold_start", 32'(tx_start_o), 0);
        check("hold_ready3", 32'(rdy_cnt[3]), 0);
        wait_idle("lock_idle");
        exp_q = '{'h011, 'h022, 'h033, 'h344};
        check_log("lock_log");

        // Start never acknowledged, then acknowledged.
        clear_counts();
        err_times = {};
        no_ack = 1'b1;
        push(2, 8'h99, 1, 0);
        t = 0;
        while (err_times.size() < 3 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("timeout_pulses_seen", 32'(t < 300), 1);
        if (err_times.size() >= 3) begin
            check("timeout_period_a", 32'(err_times[1] - err_times[0]), 9);
            check("timeout_period_b", 32'(err_times[2] - err_times[1]), 9);
        end
        check("timeout_data", 32'(tx_data_o), 32'h99);
        check("timeout_ready_once", 32'(rdy_cnt[2]), 1);
        no_ack = 1'b0;
        wait_idle("timeout_idle");
        check("timeout_ready_final", 32'(rdy_cnt[2]), 1);
        exp_q = '{'h299};
        check_log("timeout_log");

        // Move ptr to 1, then requesters 0 and 2 arrive together.
        clear_counts();
        push(0, 8'h5E, 1, 0);
        wait_idle("simul_prep_idle");
        push(0, 8'hC0, 1, 0);
        push(2, 8'hC2, 1, 0);
        wait_idle("simul_idle");
        exp_q = '{'h05E, 'h2C2, 'h0C0};
        check_log("simul_log");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual running required finished");
        $fatal(1, "watchdog");
    end

endmodule
